// File: rtl/alu_reg_loader.sv
// alu_reg_loader: buffers parallel register-write requests in a FIFO and
// sends each as a 22-bit serial frame {sel, data, parity} to the ALU reg port.
//
// Ports:
//   clk, n_rst              clock, async active-low reset
//   i_valid/o_ready         request handshake (accepted when both high)
//   i_reg_sel, i_data       5-bit target register, 16-bit value
//   o_reg_io                serial data bit (0 when enable is low)
//   o_reg_io_enable         frame-active qualifier
//   o_busy                  FSM active or FIFO non-empty
//   o_done                  one-cycle pulse after each completed frame
module alu_reg_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int BIT_DIV    = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [4:0]  i_reg_sel,
  input  logic [15:0] i_data,
  output logic        o_reg_io,
  output logic        o_reg_io_enable,
  output logic        o_busy,
  output logic        o_done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t state, state_n;

  logic [20:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, empty;
  logic [20:0]   head;

  logic [21:0]   shreg;
  logic [4:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic          div_tc;
  logic          last_bit;
  logic          done_n;

  assign empty   = (count == '0);
  assign o_ready = (count != CW'(FIFO_DEPTH));
  assign push    = i_valid && o_ready;
  assign pop     = (state == IDLE) && !empty;
  assign head    = mem[rd_ptr];
  assign o_busy  = (state != IDLE) || !empty;

  // With BIT_DIV=1 the divider never leaves 0, so every cycle is terminal.
  assign div_tc   = (div_cnt == DW'(BIT_DIV - 1));
  assign last_bit = (bit_cnt == 5'd21);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {i_reg_sel, i_data};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) state_n = SHIFT;
      end
      SHIFT: begin
        if (div_tc && last_bit) state_n = GAP;
      end
      GAP: begin
        done_n = (div_cnt == '0);
        if (div_tc) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            shreg   <= {head, ^head};
            bit_cnt <= '0;
            div_cnt <= '0;
          end
        end
        SHIFT: begin
          if (div_tc) begin
            div_cnt <= '0;
            shreg   <= {shreg[20:0], 1'b0};
            bit_cnt <= last_bit ? 5'd0 : bit_cnt + 5'd1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
        end
        default: begin
          div_cnt <= '0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  // Outputs lag the FSM by one cycle so they come straight from flops.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_reg_io        <= 1'b0;
      o_reg_io_enable <= 1'b0;
      o_done          <= 1'b0;
    end else begin
      o_reg_io_enable <= (state == SHIFT);
      o_reg_io        <= (state == SHIFT) && shreg[21];
      o_done          <= done_n;
    end
  end

endmodule

// File: tb/tb_alu_reg_loader.sv
// tb_alu_reg_loader: randomized and directed checks of alu_reg_loader
// against a frame-level reference model (FIFO order, framing, parity).
module tb_alu_reg_loader;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        v1, v3;
  logic [4:0]  sel;
  logic [15:0] data;
  logic [1:0]  rdy, ioq, enq, bsy, dn;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rise_cyc [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int mon_err  [2] = '{0, 0};
  int clen     [2] = '{0, 0};
  int lowr     [2] = '{0, 0};
  logic        prev_en [2] = '{1'b0, 1'b0};
  logic [65:0] cs      [2] = '{66'd0, 66'd0};
  bit          seen    [2] = '{1'b0, 1'b0};
  bit          rdy0_low = 1'b0;

  logic [20:0] exp1 [$];
  logic [20:0] exp3 [$];
  logic [21:0] frm1 [$];
  logic [21:0] frm3 [$];
  int          gap1 [$];

  alu_reg_loader #(.FIFO_DEPTH(4), .BIT_DIV(1)) u1 (
    .clk(clk), .n_rst(n_rst), .i_valid(v1), .o_ready(rdy[0]),
    .i_reg_sel(sel), .i_data(data), .o_reg_io(ioq[0]),
    .o_reg_io_enable(enq[0]), .o_busy(bsy[0]), .o_done(dn[0])
  );

  alu_reg_loader #(.FIFO_DEPTH(4), .BIT_DIV(3)) u3 (
    .clk(clk), .n_rst(n_rst), .i_valid(v3), .o_ready(rdy[1]),
    .i_reg_sel(sel), .i_data(data), .o_reg_io(ioq[1]),
    .o_reg_io_enable(enq[1]), .o_busy(bsy[1]), .o_done(dn[1])
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #3000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  function automatic logic [21:0] frame_of(input logic [20:0] w);
    int ones = 0;
    for (int i = 0; i < 21; i++) ones += w[i];
    return {w, 1'(ones % 2)};
  endfunction

  function automatic void decode(input logic [65:0] s, input int len,
                                 input int d, output logic [21:0] v,
                                 output bit ok);
    ok = (len == 22 * d);
    v = '0;
    if (ok) begin
      for (int i = 0; i < 22; i++) begin
        for (int j = 0; j < d; j++)
          if (s[len-1-i*d-j] !== s[len-1-i*d]) ok = 1'b0;
        v[21-i] = s[len-1-i*d];
      end
    end
  endfunction

  // Frame/strobe monitor for both instances, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (n_rst && !rdy[0]) rdy0_low = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (!n_rst) begin
        prev_en[k] = 1'b0;
        clen[k] = 0;
        seen[k] = 1'b0;
        cs[k] = '0;
      end else begin
        logic [21:0] fv;
        bit ok;
        if (dn[k] !== (prev_en[k] && !enq[k])) begin
          mon_err[k]++;
          $display("FAIL done_timing k=%0d cyc=%0d got %b", k, cyc, dn[k]);
        end
        if (dn[k] === 1'b1) done_cnt[k]++;
        if (!enq[k] && ioq[k] !== 1'b0) begin
          mon_err[k]++;
          $display("FAIL io_idle k=%0d cyc=%0d got %b want 0", k, cyc, ioq[k]);
        end
        if (enq[k]) begin
          if (!prev_en[k]) begin
            rise_cyc[k] = cyc;
            if (seen[k] && k == 0) gap1.push_back(lowr[k]);
          end
          cs[k] = {cs[k][64:0], ioq[k]};
          clen[k]++;
        end else if (prev_en[k]) begin
          decode(cs[k], clen[k], (k == 0) ? 1 : 3, fv, ok);
          if (!ok) begin
            mon_err[k]++;
            $display("FAIL frame_shape k=%0d len=%0d", k, clen[k]);
          end
          if (k == 0) frm1.push_back(fv);
          else        frm3.push_back(fv);
          clen[k] = 0;
          lowr[k] = 1;
          seen[k] = 1'b1;
        end else begin
          lowr[k]++;
        end
        prev_en[k] = enq[k];
      end
    end
  end

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [4:0] s, input logic [15:0] d);
    int guard = 0;
    sel = s;
    data = d;
    if (k == 0) v1 = 1'b1;
    else        v3 = 1'b1;
    @(negedge clk);
    while (!rdy[k] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      tests++;
      failed++;
      $display("FAIL push_timeout k=%0d got ready=0 want 1", k);
    end else begin
      acc_cyc = cyc + 1;
      if (k == 0) exp1.push_back({s, d});
      else        exp3.push_back({s, d});
    end
    @(posedge clk);
    #1;
    v1 = 1'b0;
    v3 = 1'b0;
  endtask

  task automatic wait_frames(input int k, input int n, input int budget);
    int t = 0;
    while (((k == 0) ? frm1.size() : frm3.size()) < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (t >= budget) begin
      failed++;
      $display("FAIL wait_frames k=%0d got %0d want %0d", k,
               (k == 0) ? frm1.size() : frm3.size(), n);
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    #12;
    tests++;
    if ({ioq, enq, bsy, dn} !== 8'h0) begin
      failed++;
      $display("FAIL reset_outs got %b want 0", {ioq, enq, bsy, dn});
    end
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    tests++;
    if (rdy !== 2'b11) begin
      failed++;
      $display("FAIL reset_ready got %b want 11", rdy);
    end
    tests++;
    if (bsy !== 2'b00) begin
      failed++;
      $display("FAIL reset_busy got %b want 00", bsy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    int d0 = done_cnt[0];
    logic [21:0] g, e;
    sync;
    push(0, 5'h03, 16'hA5F0);
    wait_frames(0, 1, 100);
    g = frm1.pop_front();
    e = frame_of(exp1.pop_front());
    tests++;
    if (g !== 22'b0001110100101111100000 || g !== e) begin
      failed++;
      $display("FAIL single_frame got %h want %h", g, e);
    end
    tests++;
    if (rise_cyc[0] - acc_cyc != 2) begin
      failed++;
      $display("FAIL single_latency got %0d want 2", rise_cyc[0] - acc_cyc);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (done_cnt[0] - d0 != 1) begin
      failed++;
      $display("FAIL single_done got %0d want 1", done_cnt[0] - d0);
    end
    tests++;
    if (bsy[0] !== 1'b0) begin
      failed++;
      $display("FAIL single_busy got %b want 0", bsy[0]);
    end
  endtask

  task automatic test_parity;
    logic [21:0] g;
    sync;
    push(0, 5'h01, 16'h0000);
    sync;
    push(0, 5'h1F, 16'hFFFF);
    wait_frames(0, 2, 200);
    for (int i = 0; i < 2; i++) begin
      g = frm1.pop_front();
      tests++;
      if (g !== frame_of(exp1.pop_front()) || g[0] !== 1'b1) begin
        failed++;
        $display("FAIL parity_%0d got %h", i, g);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fifo_full;
    int d0 = done_cnt[0];
    int a1, a6;
    logic [21:0] g, e;
    gap1.delete();
    rdy0_low = 1'b0;
    sync;
    for (int i = 0; i < 6; i++) begin
      push(0, 5'($urandom), {12'($urandom), 4'(i)});
      if (i == 0) a1 = acc_cyc;
      if (i == 5) a6 = acc_cyc;
    end
    tests++;
    if (!rdy0_low) begin
      failed++;
      $display("FAIL fifo_full_ready got no low want low");
    end
    tests++;
    if (a6 - a1 != 26) begin
      failed++;
      $display("FAIL fifo_ready_rise got %0d want 26", a6 - a1);
    end
    wait_frames(0, 6, 400);
    for (int i = 0; i < 6; i++) begin
      g = frm1.pop_front();
      e = frame_of(exp1.pop_front());
      tests++;
      if (g !== e) begin
        failed++;
        $display("FAIL fifo_order_%0d got %h want %h", i, g, e);
      end
    end
    tests++;
    if (gap1.size() != 6) begin
      failed++;
      $display("FAIL fifo_gap_count got %0d want 6", gap1.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        tests++;
        if (gap1[i] != 2) begin
          failed++;
          $display("FAIL fifo_gap_%0d got %0d want 2", i, gap1[i]);
        end
      end
    end
    repeat (3) @(negedge clk);
    tests++;
    if (done_cnt[0] - d0 != 6) begin
      failed++;
      $display("FAIL fifo_done got %0d want 6", done_cnt[0] - d0);
    end
  endtask

  task automatic test_divider;
    int d0 = done_cnt[1];
    logic [21:0] g;
    sync;
    push(1, 5'h10, 16'h8001);
    wait_frames(1, 1, 200);
    g = frm3.pop_front();
    tests++;
    if (g !== 22'b1000010000000000000011 || g !== frame_of(exp3.pop_front())) begin
      failed++;
      $display("FAIL div_frame got %h want %h", g, 22'b1000010000000000000011);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (mon_err[1] != 0 || done_cnt[1] - d0 != 1) begin
      failed++;
      $display("FAIL div_shape got err=%0d done=%0d want 0/1",
               mon_err[1], done_cnt[1] - d0);
    end
    mon_err[1] = 0;
  endtask

  task automatic test_reset_mid;
    int t = 0;
    int f0, d0;
    logic [21:0] g;
    sync;
    for (int i = 0; i < 3; i++) push(0, 5'($urandom), 16'($urandom));
    while (!enq[0] && t < 50) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    tests++;
    if ({ioq[0], enq[0], dn[0], bsy[0]} !== 4'b0) begin
      failed++;
      $display("FAIL rst_async got %b want 0000", {ioq[0], enq[0], dn[0], bsy[0]});
    end
    exp1.delete();
    exp3.delete();
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    tests++;
    if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      failed++;
      $display("FAIL rst_release got rdy=%b busy=%b want 1/0", rdy[0], bsy[0]);
    end
    f0 = frm1.size();
    d0 = done_cnt[0];
    repeat (80) @(negedge clk);
    tests++;
    if (frm1.size() != f0 || done_cnt[0] != d0 || bsy[0] !== 1'b0) begin
      failed++;
      $display("FAIL rst_no_resume got frames=%0d done=%0d want 0/0",
               frm1.size() - f0, done_cnt[0] - d0);
    end
    sync;
    push(0, 5'h02, 16'h1234);
    wait_frames(0, f0 + 1, 100);
    g = frm1.pop_front();
    tests++;
    if (g !== {5'h02, 16'h1234, 1'b0} || g !== frame_of(exp1.pop_front())) begin
      failed++;
      $display("FAIL rst_after got %h want %h", g, {5'h02, 16'h1234, 1'b0});
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_push_pop;
    int a1;
    logic [21:0] g, e;
    gap1.delete();
    rdy0_low = 1'b0;
    sync;
    push(0, 5'($urandom), 16'($urandom));
    a1 = acc_cyc;
    push(0, 5'($urandom), 16'($urandom));
    tests++;
    if (acc_cyc - a1 != 1) begin
      failed++;
      $display("FAIL pp_accept got %0d want 1", acc_cyc - a1);
    end
    wait_frames(0, 2, 120);
    for (int i = 0; i < 2; i++) begin
      g = frm1.pop_front();
      e = frame_of(exp1.pop_front());
      tests++;
      if (g !== e) begin
        failed++;
        $display("FAIL pp_order_%0d got %h want %h", i, g, e);
      end
    end
    tests++;
    if (rdy0_low || gap1.size() != 2 || gap1[1] != 2) begin
      failed++;
      $display("FAIL pp_ready_gap got low=%0d gaps=%0d want 0/2",
               rdy0_low, gap1.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [21:0] g, e;
    for (int i = 0; i < 8; i++) begin
      sync;
      push(0, 5'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    wait_frames(0, 8, 600);
    for (int i = 0; i < 8; i++) begin
      g = frm1.pop_front();
      e = frame_of(exp1.pop_front());
      tests++;
      if (g !== e) begin
        failed++;
        $display("FAIL b2b_%0d got %h want %h", i, g, e);
      end
    end
    repeat (3) @(negedge clk);
    tests++;
    if (mon_err[0] != 0 || bsy[0] !== 1'b0) begin
      failed++;
      $display("FAIL monitor got err=%0d busy=%b want 0/0", mon_err[0], bsy[0]);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    v1 = 1'b0;
    v3 = 1'b0;
    sel = '0;
    data = '0;
    test_reset;
    test_single;
    test_parity;
    test_fifo_full;
    test_divider;
    test_reset_mid;
    test_push_pop;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
